// File: rtl/priority_resolver_isr.sv
// 8259-style priority resolver with in-service register and two-pulse INTA handshake.
// Define PRI_ROTATE_EN to compile in rotating priority (lp_reg updates on EOI/AEOI).
module priority_resolver_isr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] risedBits,
    input  logic       inta_n,
    input  logic       eoi,
    input  logic       eoi_specific,
    input  logic [2:0] eoi_level,
    input  logic       aeoi,
    input  logic       rotate,
    output logic       INT,
    output logic       readPriority,
    output logic [2:0] resetIRR,
    output logic [7:0] isr,
    output logic       vector_valid,
    output logic [2:0] vector_level,
    output logic       spurious
);

    typedef enum logic [1:0] {IDLE, PEND, ACK1, ACK2} state_t;

    state_t     state_q, state_d;
    logic [7:0] isr_q, isr_d;
    logic [2:0] lvl_q, lvl_d;
    logic       spur_flag_q, spur_flag_d;
    logic       inta_prev_q;
    logic       rdpri_q, rdpri_d;
    logic [2:0] resetirr_q, resetirr_d;
    logic       vv_q, vv_d;
    logic [2:0] vlevel_q, vlevel_d;
    logic       spur_q, spur_d;
    logic [2:0] lp;

    logic [3:0] rb_rank;
    logic [3:0] isr_rank;
    logic       cand;
    logic [2:0] cand_lvl;
    logic [2:0] isr_top_lvl;
    logic       inta_fall;
    logic       inta_rise;

    // Rank 0 is the highest priority (level lp+1); rank 8 means no bit set.
    function automatic logic [3:0] top_rank(input logic [7:0] v, input logic [2:0] lowest);
        logic [3:0] r;
        logic [2:0] idx;
        r = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            idx = lowest + 3'd1 + 3'(i);
            if (v[idx]) r = 4'(i);
        end
        return r;
    endfunction

`ifdef PRI_ROTATE_EN
    logic [2:0] lp_q, lp_d;
    assign lp = lp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lp_q <= 3'd7;
        else        lp_q <= lp_d;
    end
`else
    logic unused_rotate;
    assign lp            = 3'd7;
    assign unused_rotate = rotate;
`endif

    always_comb begin
        rb_rank     = top_rank(risedBits, lp);
        isr_rank    = top_rank(isr_q, lp);
        cand        = (rb_rank < isr_rank);
        cand_lvl    = lp + 3'd1 + rb_rank[2:0];
        isr_top_lvl = lp + 3'd1 + isr_rank[2:0];
        inta_fall   = ~inta_n & inta_prev_q;
        inta_rise   = inta_n & ~inta_prev_q;
    end

    always_comb begin
        state_d     = state_q;
        isr_d       = isr_q;
        lvl_d       = lvl_q;
        spur_flag_d = spur_flag_q;
        rdpri_d     = 1'b0;
        resetirr_d  = resetirr_q;
        vv_d        = 1'b0;
        vlevel_d    = vlevel_q;
        spur_d      = 1'b0;
`ifdef PRI_ROTATE_EN
        lp_d        = lp_q;
`endif

        // EOI lands first so a same-cycle grant or AEOI clear overrides it.
        if (eoi) begin
            if (eoi_specific) begin
                isr_d[eoi_level] = 1'b0;
`ifdef PRI_ROTATE_EN
                if (rotate) lp_d = eoi_level;
`endif
            end else if (isr_rank != 4'd8) begin
                isr_d[isr_top_lvl] = 1'b0;
`ifdef PRI_ROTATE_EN
                if (rotate) lp_d = isr_top_lvl;
`endif
            end
        end

        case (state_q)
            IDLE: begin
                if (cand) state_d = PEND;
            end
            PEND: begin
                if (inta_fall) begin
                    state_d = ACK1;
                    if (cand) begin
                        lvl_d           = cand_lvl;
                        spur_flag_d     = 1'b0;
                        isr_d[cand_lvl] = 1'b1;
                        rdpri_d         = 1'b1;
                        resetirr_d      = cand_lvl;
                    end else begin
                        lvl_d       = 3'd7;
                        spur_flag_d = 1'b1;
                    end
                end else if (!cand) begin
                    state_d = IDLE;
                end
            end
            ACK1: begin
                if (inta_fall) begin
                    state_d  = ACK2;
                    vv_d     = 1'b1;
                    vlevel_d = lvl_q;
                    spur_d   = spur_flag_q;
                    if (aeoi && !spur_flag_q) begin
                        isr_d[lvl_q] = 1'b0;
`ifdef PRI_ROTATE_EN
                        if (rotate) lp_d = lvl_q;
`endif
                    end
                end
            end
            ACK2: begin
                if (inta_rise) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            isr_q       <= 8'h00;
            lvl_q       <= 3'd0;
            spur_flag_q <= 1'b0;
            inta_prev_q <= 1'b1;
            rdpri_q     <= 1'b0;
            resetirr_q  <= 3'd0;
            vv_q        <= 1'b0;
            vlevel_q    <= 3'd0;
            spur_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            isr_q       <= isr_d;
            lvl_q       <= lvl_d;
            spur_flag_q <= spur_flag_d;
            inta_prev_q <= inta_n;
            rdpri_q     <= rdpri_d;
            resetirr_q  <= resetirr_d;
            vv_q        <= vv_d;
            vlevel_q    <= vlevel_d;
            spur_q      <= spur_d;
        end
    end

    assign INT          = (state_q != IDLE);
    assign readPriority = rdpri_q;
    assign resetIRR     = resetirr_q;
    assign isr          = isr_q;
    assign vector_valid = vv_q;
    assign vector_level = vlevel_q;
    assign spurious     = spur_q;

endmodule
